shift_seq_ctrl: RTL and testbench

SHIFT_SEQ_CTRL -- requirements
Module: shift_seq_ctrl

---
 rtl/shift_seq_ctrl.sv | 141 ++++++++++++++
 tb/tb_shift_seq_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: sequences load / rotate / shift commands into an external
// shift register that has no hold command. The result is captured when the
// sequence finishes, and done pulses for one cycle.
module shift_seq_ctrl #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] init_data,
   input  logic [WIDTH-1:0] ser_data,
   input  logic [CW-1:0]    count,
   input  logic [WIDTH-1:0] sr_data,
   output logic [1:0]       cmd,
   output logic [WIDTH-1:0] par_in,
   output logic             ser_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOAD   = 2'd1,
      SHIFT  = 2'd2,
      FINISH = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q, op_d;
   logic [WIDTH-1:0] init_q, init_d;
   logic [WIDTH-1:0] ser_q, ser_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [CW-1:0]    k_q, k_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             ser_bit;

   // State and captured-operand registers, cleared by asynchronous reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= '0;
         init_q   <= '0;
         ser_q    <= '0;
         cnt_q    <= '0;
         k_q      <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         init_q   <= init_d;
         ser_q    <= ser_d;
         cnt_q    <= cnt_d;
         k_q      <= k_d;
         done_q   <= done_d;
         result_q <= result_d;
      end
   end

   // Next-state logic: capture on start in IDLE, step through SHIFT, report in FINISH
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      init_d   = init_q;
      ser_d    = ser_q;
      cnt_d    = cnt_q;
      k_d      = k_q;
      done_d   = 1'b0;
      result_d = result_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = op;
               init_d  = init_data;
               ser_d   = ser_data;
               cnt_d   = count;
               k_d     = '0;
               state_d = LOAD;
            end
         end
         LOAD: begin
            k_d = '0;
            if (cnt_q == '0 || op_q == 2'd0) begin
               state_d = FINISH;
            end else begin
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (k_q == cnt_q - CW'(1)) begin
               state_d = FINISH;
            end else begin
               k_d = k_q + CW'(1);
            end
         end
         FINISH: begin
            done_d   = 1'b1;
            result_d = sr_data;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Serial bit for step k; steps at or beyond WIDTH feed zeros
   always_comb begin
      ser_bit = 1'b0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
         if (k_q == CW'(i)) begin
            ser_bit = ser_q[i];
         end
      end
   end

   // Shift-register command decode from registered state; IDLE/FINISH reload current contents
   always_comb begin
      cmd    = 2'd0;
      par_in = sr_data;
      ser_in = 1'b0;
      case (state_q)
         LOAD: begin
            par_in = init_q;
         end
         SHIFT: begin
            cmd    = op_q;
            par_in = init_q;
            ser_in = (op_q == 2'd3) ? ser_bit : 1'b0;
         end
         default: ;
      endcase
   end

   assign busy   = (state_q != IDLE);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl with a behavioural downstream shift register.
module tb_shift_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [1:0] op = 2'd0;
   logic [7:0] init_data = 8'h00;
   logic [7:0] ser_data = 8'h00;
   logic [3:0] count = 4'd0;
   logic [7:0] sr = 8'h00;
   logic [1:0] cmd;
   logic [7:0] par_in;
   logic       ser_in;
   logic       busy;
   logic       done;
   logic [7:0] result;

   int nvec = 0;
   int nerr = 0;

   shift_seq_ctrl #(.WIDTH(8), .CW(4)) dut (
      .clk(clk), .rst(rst), .start(start), .op(op), .init_data(init_data),
      .ser_data(ser_data), .count(count), .sr_data(sr), .cmd(cmd),
      .par_in(par_in), .ser_in(ser_in), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   // Downstream shift register: load, rotate left, rotate right, shift right (serial into MSB)
   always @(posedge clk) begin
      case (cmd)
         2'd0: sr <= par_in;
         2'd1: sr <= {sr[6:0], sr[7]};
         2'd2: sr <= {sr[0], sr[7:1]};
         2'd3: sr <= {ser_in, sr[7:1]};
         default: sr <= sr;
      endcase
   end

   // Runs one sequence; returns edges from sampling edge to done (inclusive),
   // number of SHIFT cycles seen, and the ser_in trace per step.
   task automatic do_seq(input logic [1:0] o, input logic [7:0] ini, input logic [7:0] sd,
                         input logic [3:0] c, output int lat, output int nsh,
                         output logic [15:0] tr);
      lat = 0; nsh = 0; tr = '0;
      @(negedge clk);
      start = 1'b1; op = o; init_data = ini; ser_data = sd; count = c;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      start = 1'b0; op = 2'd2; init_data = 8'hEE; ser_data = 8'h00; count = 4'd9;
      for (int i = 0; i < 100; i++) begin
         if (done) break;
         if (busy && cmd != 2'd0) begin
            if (nsh < 16) tr[nsh] = ser_in;
            nsh++;
         end
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      nvec++; if (busy !== 1'b0) begin $display("FAIL reset_busy: got %b expected 0", busy); nerr++; end
      nvec++; if (done !== 1'b0) begin $display("FAIL reset_done: got %b expected 0", done); nerr++; end
      nvec++; if (result !== 8'h00) begin $display("FAIL reset_result: got %h expected 00", result); nerr++; end
      nvec++; if (cmd !== 2'd0) begin $display("FAIL reset_cmd: got %0d expected 0", cmd); nerr++; end
      nvec++; if (ser_in !== 1'b0) begin $display("FAIL reset_ser_in: got %b expected 0", ser_in); nerr++; end
      nvec++; if (par_in !== sr) begin $display("FAIL reset_par_in: got %h expected %h", par_in, sr); nerr++; end
      rst = 1'b0;
   endtask

   task automatic test_shift_right();
      int lat, nsh; logic [15:0] tr;
      do_seq(2'd3, 8'h00, 8'hA5, 4'd8, lat, nsh, tr);
      nvec++; if (lat != 11) begin $display("FAIL shr_latency: got %0d expected 11", lat); nerr++; end
      nvec++; if (nsh != 8) begin $display("FAIL shr_steps: got %0d expected 8", nsh); nerr++; end
      nvec++; if (tr[7:0] !== 8'hA5) begin $display("FAIL shr_ser_trace: got %h expected a5", tr[7:0]); nerr++; end
      nvec++; if (result !== 8'hA5) begin $display("FAIL shr_result: got %h expected a5", result); nerr++; end
      nvec++; if (busy !== 1'b0) begin $display("FAIL shr_busy_at_done: got %b expected 0", busy); nerr++; end
      @(posedge clk); @(negedge clk);
      nvec++; if (done !== 1'b0) begin $display("FAIL shr_done_pulse_width: got %b expected 0", done); nerr++; end
   endtask

   task automatic test_rotate();
      int lat, nsh; logic [15:0] tr;
      do_seq(2'd1, 8'h81, 8'h00, 4'd1, lat, nsh, tr);
      nvec++; if (result !== 8'h03) begin $display("FAIL rotl_result: got %h expected 03", result); nerr++; end
      nvec++; if (lat != 4) begin $display("FAIL rotl_latency: got %0d expected 4", lat); nerr++; end
      do_seq(2'd2, 8'h01, 8'hFF, 4'd3, lat, nsh, tr);
      nvec++; if (result !== 8'h20) begin $display("FAIL rotr_result: got %h expected 20", result); nerr++; end
      nvec++; if (lat != 6) begin $display("FAIL rotr_latency: got %0d expected 6", lat); nerr++; end
      nvec++; if (tr[2:0] !== 3'b000) begin $display("FAIL rotr_ser_in_zero: got %b expected 000", tr[2:0]); nerr++; end
   endtask

   task automatic test_no_shift();
      int lat, nsh; logic [15:0] tr;
      do_seq(2'd0, 8'h5C, 8'h00, 4'd5, lat, nsh, tr);
      nvec++; if (lat != 3) begin $display("FAIL load_only_latency: got %0d expected 3", lat); nerr++; end
      nvec++; if (nsh != 0) begin $display("FAIL load_only_steps: got %0d expected 0", nsh); nerr++; end
      nvec++; if (result !== 8'h5C) begin $display("FAIL load_only_result: got %h expected 5c", result); nerr++; end
      do_seq(2'd1, 8'h5C, 8'h00, 4'd0, lat, nsh, tr);
      nvec++; if (lat != 3) begin $display("FAIL count0_latency: got %0d expected 3", lat); nerr++; end
      nvec++; if (nsh != 0) begin $display("FAIL count0_steps: got %0d expected 0", nsh); nerr++; end
      nvec++; if (result !== 8'h5C) begin $display("FAIL count0_result: got %h expected 5c", result); nerr++; end
   endtask

   task automatic test_wrap();
      int lat, nsh; logic [15:0] tr;
      do_seq(2'd1, 8'h96, 8'h00, 4'd15, lat, nsh, tr);
      nvec++; if (result !== 8'h4B) begin $display("FAIL rotl15_result: got %h expected 4b", result); nerr++; end
      nvec++; if (lat != 18) begin $display("FAIL rotl15_latency: got %0d expected 18", lat); nerr++; end
      // eight ones enter, then two zeros for steps 8 and 9 push the MSBs low
      do_seq(2'd3, 8'hFF, 8'hFF, 4'd10, lat, nsh, tr);
      nvec++; if (tr[9:0] !== 10'h0FF) begin $display("FAIL shr10_ser_trace: got %h expected 0ff", tr[9:0]); nerr++; end
      nvec++; if (result !== 8'h3F) begin $display("FAIL shr10_result: got %h expected 3f", result); nerr++; end
      nvec++; if (lat != 13) begin $display("FAIL shr10_latency: got %0d expected 13", lat); nerr++; end
   endtask

   task automatic test_busy_ignore();
      logic got;
      @(negedge clk);
      start = 1'b1; op = 2'd1; init_data = 8'h81; count = 4'd2;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      start = 1'b1; op = 2'd2; init_data = 8'h55; count = 4'd7;
      @(negedge clk);
      start = 1'b0;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      nvec++; if (got !== 1'b1) begin $display("FAIL ignore_done_seen: got %b expected 1", got); nerr++; end
      nvec++; if (result !== 8'h06) begin $display("FAIL ignore_result: got %h expected 06", result); nerr++; end
      @(negedge clk);
      nvec++; if (busy !== 1'b0) begin $display("FAIL ignore_no_restart: got %b expected 0", busy); nerr++; end
   endtask

   task automatic test_back_to_back();
      logic got;
      @(negedge clk);
      start = 1'b1; op = 2'd1; init_data = 8'h81; count = 4'd1;
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      nvec++; if (got !== 1'b1) begin $display("FAIL b2b_first_done: got %b expected 1", got); nerr++; end
      nvec++; if (result !== 8'h03) begin $display("FAIL b2b_first_result: got %h expected 03", result); nerr++; end
      op = 2'd2; init_data = 8'h01; count = 4'd3;
      @(negedge clk);
      start = 1'b0;
      nvec++; if (busy !== 1'b1) begin $display("FAIL b2b_second_busy: got %b expected 1", busy); nerr++; end
      nvec++; if (par_in !== 8'h01) begin $display("FAIL b2b_second_load: got %h expected 01", par_in); nerr++; end
      nvec++; if (result !== 8'h03) begin $display("FAIL b2b_result_hold: got %h expected 03", result); nerr++; end
      got = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (done) begin got = 1'b1; break; end
      end
      nvec++; if (got !== 1'b1) begin $display("FAIL b2b_second_done: got %b expected 1", got); nerr++; end
      nvec++; if (result !== 8'h20) begin $display("FAIL b2b_second_result: got %h expected 20", result); nerr++; end
   endtask

   task automatic test_reset_abort();
      int lat, nsh, seen; logic [15:0] tr; logic [7:0] sr_hold;
      @(negedge clk);
      start = 1'b1; op = 2'd3; init_data = 8'h00; ser_data = 8'hA5; count = 4'd8;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      nvec++; if (busy !== 1'b0) begin $display("FAIL abort_busy: got %b expected 0", busy); nerr++; end
      nvec++; if (result !== 8'h00) begin $display("FAIL abort_result_cleared: got %h expected 00", result); nerr++; end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      sr_hold = sr;
      seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (done) seen++;
      end
      nvec++; if (seen != 0) begin $display("FAIL abort_no_done: got %0d expected 0", seen); nerr++; end
      nvec++; if (sr !== sr_hold) begin $display("FAIL abort_sr_steady: got %h expected %h", sr, sr_hold); nerr++; end
      do_seq(2'd2, 8'h01, 8'h00, 4'd3, lat, nsh, tr);
      nvec++; if (result !== 8'h20) begin $display("FAIL abort_recover_result: got %h expected 20", result); nerr++; end
      nvec++; if (lat != 6) begin $display("FAIL abort_recover_latency: got %0d expected 6", lat); nerr++; end
   endtask

   initial begin
      test_reset();
      test_shift_right();
      test_rotate();
      test_no_shift();
      test_wrap();
      test_busy_ignore();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
